// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT frame sequencer.
// Holds the sequencer FSM states, the default frame geometry and a counter-width helper.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam int DEF_FFT_POINTS = 1024;
    localparam int DEF_DATA_W     = 24;
    localparam int CNT_W          = $clog2(DEF_FFT_POINTS);

    function automatic int cnt_w(input int points);
        return $clog2(points);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small skid FIFO between sample capture and the FFT sink.
// The head word is held in a register so the sink data is a flop output.
module sample_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 4
) (
    input  logic              MCLK,
    input  logic              reset,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_inc;
    logic [PTR_W:0]    count_reg;
    logic [DATA_W-1:0] head_reg;
    logic              wr_ok;
    logic              rd_ok;

    assign full       = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty      = (count_reg == '0);
    assign rd_ok      = rd_en && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_ok      = wr_en && (!full || rd_ok);
    assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);
    assign head       = head_reg;

    always_ff @(posedge MCLK) begin
        if (wr_ok && !flush) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
            // Next head comes from storage, or straight from the write port when the FIFO runs dry.
            if (rd_ok) begin
                if (count_reg > (PTR_W+1)'(1)) begin
                    head_reg <= mem[rd_ptr_inc];
                end else if (wr_ok) begin
                    head_reg <= wr_data;
                end
            end else if (wr_ok && empty) begin
                head_reg <= wr_data;
            end
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frames the audio sample stream into the FFT core sink and monitors the FFT source stream
// for bin position, completed frames and framing errors.
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int FFT_POINTS = DEF_FFT_POINTS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int BIN_W      = cnt_w(FFT_POINTS)
) (
    input  logic              MCLK,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              sink_ready,
    output logic              sink_valid,
    output logic              sink_sop,
    output logic              sink_eop,
    output logic [DATA_W-1:0] sink_real,
    output logic [DATA_W-1:0] sink_imag,
    input  logic              source_valid,
    input  logic              source_sop,
    input  logic              source_eop,
    input  logic [1:0]        source_error,
    output logic              source_ready,
    output logic [BIN_W-1:0]  bin_index,
    output logic              frame_done,
    output logic              overflow,
    output logic              frame_error,
    output logic              busy
);

    localparam logic [BIN_W-1:0] LAST = BIN_W'(FFT_POINTS - 1);

    state_t            state_reg;
    logic [BIN_W-1:0]  out_cnt_reg;
    logic [BIN_W-1:0]  bin_index_reg;
    logic [BIN_W-1:0]  bin_next;
    logic              source_ready_reg;
    logic              frame_done_reg;
    logic              overflow_reg;
    logic              frame_error_reg;
    logic              in_frame_reg;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_wr;
    logic              fifo_rd;
    logic              fifo_flush;
    logic [DATA_W-1:0] fifo_head;
    logic              sink_valid_int;
    logic              eop_exit;
    logic              src_accept;
    logic              err_hit;

    always_comb begin
        sink_valid_int = !fifo_empty && (state_reg != ERROR);
        fifo_rd        = sink_valid_int && sink_ready;
        // Framing stops only once the frame in flight has delivered its eop.
        eop_exit       = (state_reg == RUN) && fifo_rd && (out_cnt_reg == LAST) && !enable;
        fifo_flush     = (state_reg == ERROR) || eop_exit;
        fifo_wr        = sample_valid && (((state_reg == IDLE) && enable) || (state_reg == RUN));
        src_accept     = source_valid && source_ready_reg;
        err_hit        = source_valid && (source_error != 2'b00) && (state_reg != ERROR);
        bin_next       = source_sop ? '0 : bin_index_reg + BIN_W'(1);
    end

    sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .MCLK    (MCLK),
        .reset   (reset),
        .flush   (fifo_flush),
        .wr_en   (fifo_wr),
        .wr_data (sample_in),
        .rd_en   (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            source_ready_reg <= 1'b0;
        end else begin
            source_ready_reg <= 1'b1;
            if (err_hit) begin
                state_reg        <= ERROR;
                source_ready_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE:    if (sample_valid && enable) state_reg <= RUN;
                    RUN:     if (eop_exit) state_reg <= IDLE;
                    ERROR: begin
                        if (!enable) begin
                            state_reg <= IDLE;
                        end else begin
                            source_ready_reg <= 1'b0;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            out_cnt_reg     <= '0;
            bin_index_reg   <= '0;
            frame_done_reg  <= 1'b0;
            overflow_reg    <= 1'b0;
            frame_error_reg <= 1'b0;
            in_frame_reg    <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (state_reg == ERROR) begin
                out_cnt_reg <= '0;
            end else if (fifo_rd) begin
                out_cnt_reg <= out_cnt_reg + BIN_W'(1);
            end
            if ((state_reg == RUN) && sample_valid && fifo_full && !fifo_rd) begin
                overflow_reg <= 1'b1;
            end
            if (state_reg == ERROR) begin
                bin_index_reg <= '0;
                in_frame_reg  <= 1'b0;
            end else if (err_hit) begin
                frame_error_reg <= 1'b1;
                bin_index_reg   <= '0;
                in_frame_reg    <= 1'b0;
            end else if (src_accept) begin
                bin_index_reg  <= bin_next;
                frame_done_reg <= source_eop && (bin_next == LAST);
                if ((source_eop && (bin_next != LAST)) || (source_sop && in_frame_reg)) begin
                    frame_error_reg <= 1'b1;
                end
                if (source_eop) begin
                    in_frame_reg <= 1'b0;
                end else if (source_sop) begin
                    in_frame_reg <= 1'b1;
                end
            end
        end
    end

    assign sink_valid   = sink_valid_int;
    assign sink_sop     = sink_valid_int && (out_cnt_reg == '0);
    assign sink_eop     = sink_valid_int && (out_cnt_reg == LAST);
    assign sink_real    = fifo_head;
    assign sink_imag    = '0;
    assign source_ready = source_ready_reg;
    assign bin_index    = bin_index_reg;
    assign frame_done   = frame_done_reg;
    assign overflow     = overflow_reg;
    assign frame_error  = frame_error_reg;
    assign busy         = (state_reg == RUN);

endmodule
